// File: rtl/gpu_clock_controller.sv
`default_nettype none
// ============================================================================
// Module   : gpu_clock_controller
// Purpose  : GPU clock pass-through, power-on enable delay and NUM_CH
//            clock-enable strobe channels with glitch-free runtime divisors.
//            Optional soft reset input when GPU_CLKCTRL_SOFTRESET_EN is defined.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module gpu_clock_controller #(
    parameter int STARTUP_CYCLES = 100,
    parameter int CNT_W          = 16,
    parameter int NUM_CH         = 4,
    parameter int DIV_W          = 8,
    parameter int DIV_DEFAULT    = 1,
    localparam int SEL_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_wire_clock,
    input  logic              i_wire_resetn,
`ifdef GPU_CLKCTRL_SOFTRESET_EN
    input  logic              i_wire_soft_rst,
`endif
    input  logic              i_wire_div_wr,
    input  logic [SEL_W-1:0]  i_wire_div_sel,
    input  logic [DIV_W-1:0]  i_wire_div_data,
    output logic              o_wire_clock,
    output logic              o_wire_enabled,
    output logic [NUM_CH-1:0] o_wire_ce,
    output logic [NUM_CH-1:0] o_wire_div_busy
);

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_startup     = CNT_W'(STARTUP_CYCLES);
    localparam logic [DIV_W-1:0] c_div_default = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] c_div_one     = DIV_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_startup_cnt;
    logic             r_enabled;
    logic             w_soft_rst;

`ifdef GPU_CLKCTRL_SOFTRESET_EN
    assign w_soft_rst = i_wire_soft_rst;
`else
    assign w_soft_rst = 1'b0;
`endif

    assign o_wire_clock   = i_wire_clock;
    assign o_wire_enabled = r_enabled;

    // Startup sequencer: the counter saturates at STARTUP_CYCLES, so it never wraps.
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            r_state       <= ST_WAIT;
            r_startup_cnt <= '0;
            r_enabled     <= 1'b0;
        end else if (w_soft_rst) begin
            r_state       <= ST_WAIT;
            r_startup_cnt <= '0;
            r_enabled     <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_startup_cnt < c_startup) begin
                        r_startup_cnt <= r_startup_cnt + CNT_W'(1);
                    end else begin
                        r_enabled <= 1'b1;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_enabled <= 1'b1;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] r_act_div;
        logic [DIV_W-1:0] r_pend_div;
        logic [DIV_W-1:0] r_phase;
        logic             r_ce;
        logic             r_busy;
        logic             w_sel_hit;
        logic [DIV_W-1:0] w_last_phase;
        logic             w_wrap;

        // Out-of-range selects match no channel and are therefore ignored.
        assign w_sel_hit    = i_wire_div_wr && (i_wire_div_sel == SEL_W'(g));
        assign w_last_phase = (r_act_div == '0) ? '0 : (r_act_div - c_div_one);
        assign w_wrap       = (r_phase == w_last_phase);

        always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
            if (!i_wire_resetn) begin
                r_act_div  <= c_div_default;
                r_pend_div <= c_div_default;
                r_phase    <= '0;
                r_ce       <= 1'b0;
                r_busy     <= 1'b0;
            end else if (w_soft_rst) begin
                r_phase <= '0;
                r_ce    <= 1'b0;
                r_busy  <= 1'b0;
                if (w_sel_hit) begin
                    r_act_div  <= i_wire_div_data;
                    r_pend_div <= i_wire_div_data;
                end else begin
                    r_act_div <= r_pend_div;
                end
            end else if (!r_enabled) begin
                r_phase <= '0;
                r_ce    <= 1'b0;
                r_busy  <= 1'b0;
                if (w_sel_hit) begin
                    r_act_div  <= i_wire_div_data;
                    r_pend_div <= i_wire_div_data;
                end
            end else begin
                // New divisors take effect only at a period boundary.
                if (w_wrap) begin
                    r_phase   <= '0;
                    r_ce      <= 1'b1;
                    r_act_div <= r_pend_div;
                    r_busy    <= 1'b0;
                end else begin
                    r_phase <= r_phase + c_div_one;
                    r_ce    <= 1'b0;
                end
                if (w_sel_hit) begin
                    r_pend_div <= i_wire_div_data;
                    r_busy     <= 1'b1;
                end
            end
        end

        assign o_wire_ce[g]       = r_ce;
        assign o_wire_div_busy[g] = r_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_gpu_clock_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpu_clock_controller
// Purpose  : Scoreboard bench for gpu_clock_controller against an
//            event-time reference model (strobe times as absolute cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpu_clock_controller;

    localparam int STARTUP = 100;
    localparam int NUM_CH  = 5;
    localparam int DIV_W   = 4;
    localparam int DIV_DEF = 1;
    localparam int SEL_W   = 3;

    typedef struct packed {
        logic              en;
        logic [NUM_CH-1:0] ce;
        logic [NUM_CH-1:0] busy;
    } exp_t;

    logic              clk    = 1'b0;
    logic              resetn = 1'b1;
    logic              div_wr = 1'b0;
    logic [SEL_W-1:0]  div_sel = '0;
    logic [DIV_W-1:0]  div_data = '0;
`ifdef GPU_CLKCTRL_SOFTRESET_EN
    logic              soft_rst = 1'b0;
`endif
    logic              clk_out;
    logic              enabled;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] busy;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t q[$];

    // Reference model state: strobe schedule kept as absolute cycle numbers.
    int              m_edges;
    bit              m_en;
    int              m_t;
    int              m_act [NUM_CH];
    int              m_pend[NUM_CH];
    int              m_next[NUM_CH];
    bit [NUM_CH-1:0] m_busy;
    bit [NUM_CH-1:0] m_ce;

    always #5 clk = ~clk;

    gpu_clock_controller #(
        .STARTUP_CYCLES(STARTUP),
        .CNT_W         (16),
        .NUM_CH        (NUM_CH),
        .DIV_W         (DIV_W),
        .DIV_DEFAULT   (DIV_DEF)
    ) dut (
        .i_wire_clock    (clk),
        .i_wire_resetn   (resetn),
`ifdef GPU_CLKCTRL_SOFTRESET_EN
        .i_wire_soft_rst (soft_rst),
`endif
        .i_wire_div_wr   (div_wr),
        .i_wire_div_sel  (div_sel),
        .i_wire_div_data (div_data),
        .o_wire_clock    (clk_out),
        .o_wire_enabled  (enabled),
        .o_wire_ce       (ce),
        .o_wire_div_busy (busy)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        else
            n_pass++;
    endfunction

    function automatic int eff(int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic void model_reset();
        m_edges = 0;
        m_en    = 1'b0;
        m_t     = 0;
        m_busy  = '0;
        m_ce    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_act[c]  = DIV_DEF;
            m_pend[c] = DIV_DEF;
            m_next[c] = 0;
        end
    endfunction

    function automatic void model_edge(bit wr, int s, int d, bit srst);
        exp_t e;
        m_ce = '0;
        if (srst) begin
            m_edges = 0;
            m_en    = 1'b0;
            m_busy  = '0;
            for (int c = 0; c < NUM_CH; c++) m_act[c] = m_pend[c];
        end else if (!m_en) begin
            m_edges++;
            if (wr && s < NUM_CH) begin
                m_act[s]  = d;
                m_pend[s] = d;
            end
            if (m_edges == STARTUP + 1) begin
                m_en = 1'b1;
                m_t  = 0;
                for (int c = 0; c < NUM_CH; c++) m_next[c] = eff(m_act[c]);
            end
        end else begin
            m_t++;
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_t == m_next[c]) begin
                    m_ce[c]   = 1'b1;
                    m_act[c]  = m_pend[c];
                    m_busy[c] = 1'b0;
                    m_next[c] = m_t + eff(m_act[c]);
                end
            end
            if (wr && s < NUM_CH) begin
                m_pend[s] = d;
                m_busy[s] = 1'b1;
            end
        end
        e.en   = m_en;
        e.ce   = m_ce;
        e.busy = m_busy;
        q.push_back(e);
    endfunction

    // Called at a falling edge: drive, take one rising edge, predict, return at next falling edge.
    task automatic step(bit wr, int s, int d, bit srst);
        div_wr   = wr;
        div_sel  = SEL_W'(s);
        div_data = DIV_W'(d);
`ifdef GPU_CLKCTRL_SOFTRESET_EN
        soft_rst = srst;
`endif
        @(posedge clk);
        model_edge(wr, s, d, srst);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic rand_steps(int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 15)), 1'b0);
    endtask

    // Monitor: every falling edge with a pending prediction is compared.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("enabled", 32'(enabled), 32'(e.en));
            check("ce",      32'(ce),      32'(e.ce));
            check("busy",    32'(busy),    32'(e.busy));
        end
    end

    initial begin
        model_reset();
        #2 resetn = 1'b0;
        #1;
        check("rst_enabled", 32'(enabled), 32'd0);
        check("rst_ce",      32'(ce),      32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        @(posedge clk);
        #1 check("clk_pass_hi", 32'(clk_out), 32'd1);
        @(negedge clk);
        check("clk_pass_lo", 32'(clk_out), 32'd0);
        resetn = 1'b1;

        // Startup with a divisor-0 write and an out-of-range write during WAIT
        idle(40);
        step(1'b1, 1, 0, 1'b0);
        idle(10);
        step(1'b1, 5, 7, 1'b0);
        step(1'b1, 3, 3, 1'b0);
        idle(60);

        // Channel 2 at div 4, then change to div 2 mid-period
        step(1'b1, 2, 4, 1'b0);
        idle(9);
        step(1'b1, 2, 2, 1'b0);
        idle(12);

        rand_steps(600);

        // Asynchronous reset between edges, mid-run
        #2 resetn = 1'b0;
        #1;
        check("arst_enabled", 32'(enabled), 32'd0);
        check("arst_ce",      32'(ce),      32'd0);
        check("arst_busy",    32'(busy),    32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        idle(110);

`ifdef GPU_CLKCTRL_SOFTRESET_EN
        step(1'b1, 0, 5, 1'b0);
        idle(12);
        step(1'b0, 0, 0, 1'b1);
        idle(115);
`endif

        rand_steps(300);

        #1 check("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
